// File: rtl/dmac_main_controller_pkg.sv
// Shared types and encodings for the DMAC main controller and its bus bundle.
package dmac_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_BUS_REQ,
    ST_LATCH,
    ST_CFG_ADDR,
    ST_CFG_DATA,
    ST_CHECK,
    ST_START,
    ST_XFER,
    ST_DONE,
    ST_ABORT
  } dmac_ctrl_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  localparam logic [1:0] CON_SEL_CH1 = 2'b00;
  localparam logic [1:0] CON_SEL_CH2 = 2'b01;
  localparam logic [1:0] CON_SEL_CFG = 2'b10;

  localparam logic [1:0] CFG_IDX_DADDR = 2'd0;
  localparam logic [1:0] CFG_IDX_SIZE  = 2'd1;
  localparam logic [1:0] CFG_IDX_CTRL  = 2'd2;

  // Peripheral 2 wins when both requests were latched, matching the datapath address decode.
  function automatic logic [1:0] chanFromReq(input logic [1:0] reqReg);
    logic [1:0] sel;
    case (reqReg)
      2'b10, 2'b11: sel = CON_SEL_CH2;
      default:      sel = CON_SEL_CH1;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/dmac_main_controller_if.sv
// Handshake and datapath-control bundle between the DMAC main controller and its datapath/bus.
interface dmac_main_controller_if;

  logic [1:0] DmacReq;
  logic       HGrant;
  logic       HReady;
  logic [1:0] M_HResp;
  logic       C_config;
  logic       irq;
  logic [1:0] DmacReq_Reg;

  logic       HBusReq;
  logic       config_write;
  logic [1:0] config_HTrans;
  logic [1:0] addr_inc_sel;
  logic [1:0] con_sel;
  logic       con_en;
  logic       DmacReq_Reg_en;
  logic       SAddr_Reg_en;
  logic       DAddr_Reg_en;
  logic       Trans_sz_Reg_en;
  logic       Ctrl_Reg_en;
  logic       channel_en_1;
  logic       channel_en_2;
  logic [1:0] DmacAck;
  logic       cfg_err;

  modport master (
    input  DmacReq, HGrant, HReady, M_HResp, C_config, irq, DmacReq_Reg,
    output HBusReq, config_write, config_HTrans, addr_inc_sel, con_sel, con_en,
           DmacReq_Reg_en, SAddr_Reg_en, DAddr_Reg_en, Trans_sz_Reg_en, Ctrl_Reg_en,
           channel_en_1, channel_en_2, DmacAck, cfg_err
  );

  modport slave (
    output DmacReq, HGrant, HReady, M_HResp, C_config, irq, DmacReq_Reg,
    input  HBusReq, config_write, config_HTrans, addr_inc_sel, con_sel, con_en,
           DmacReq_Reg_en, SAddr_Reg_en, DAddr_Reg_en, Trans_sz_Reg_en, Ctrl_Reg_en,
           channel_en_1, channel_en_2, DmacAck, cfg_err
  );

endinterface

// File: rtl/dmac_main_controller.sv
// DMAC main control FSM: arbitration, bus acquisition, three-word config fetch,
// channel run and completion acknowledge.
module dmac_main_controller
  import dmac_pkg::*;
(
  input logic              clk,
  input logic              rst,
  dmac_main_controller_if.master bus
);

  dmac_ctrl_state_e state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       chanSel;

  assign chanSel = chanFromReq(bus.DmacReq_Reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= CFG_IDX_DADDR;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    idx_d                = idx_q;
    bus.HBusReq          = 1'b0;
    bus.config_write     = 1'b0;
    bus.config_HTrans    = HTRANS_IDLE;
    bus.addr_inc_sel     = idx_q;
    bus.con_sel          = CON_SEL_CFG;
    bus.con_en           = 1'b0;
    bus.DmacReq_Reg_en   = 1'b0;
    bus.SAddr_Reg_en     = 1'b0;
    bus.DAddr_Reg_en     = 1'b0;
    bus.Trans_sz_Reg_en  = 1'b0;
    bus.Ctrl_Reg_en      = 1'b0;
    bus.channel_en_1     = 1'b0;
    bus.channel_en_2     = 1'b0;
    bus.DmacAck          = 2'b00;
    bus.cfg_err          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.DmacReq != 2'b00) state_d = ST_BUS_REQ;
      end
      ST_BUS_REQ: begin
        bus.HBusReq = 1'b1;
        if (bus.HGrant && bus.HReady) state_d = ST_LATCH;
        else if (bus.DmacReq == 2'b00) state_d = ST_IDLE;
      end
      ST_LATCH: begin
        bus.HBusReq        = 1'b1;
        bus.DmacReq_Reg_en = 1'b1;
        bus.SAddr_Reg_en   = 1'b1;
        idx_d              = CFG_IDX_DADDR;
        state_d            = ST_CFG_ADDR;
      end
      ST_CFG_ADDR: begin
        bus.HBusReq       = 1'b1;
        bus.config_HTrans = HTRANS_NONSEQ;
        if (bus.HReady) state_d = ST_CFG_DATA;
      end
      ST_CFG_DATA: begin
        // Loads are gated combinationally so the datapath captures MRData on this very edge.
        bus.HBusReq = 1'b1;
        if (bus.M_HResp == HRESP_ERROR) begin
          state_d = ST_ABORT;
        end else if (bus.HReady && bus.M_HResp == HRESP_OKAY) begin
          case (idx_q)
            CFG_IDX_DADDR: bus.DAddr_Reg_en    = 1'b1;
            CFG_IDX_SIZE:  bus.Trans_sz_Reg_en = 1'b1;
            default:       bus.Ctrl_Reg_en     = 1'b1;
          endcase
          if (idx_q == CFG_IDX_CTRL) begin
            state_d = ST_CHECK;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_CFG_ADDR;
          end
        end
      end
      ST_CHECK: begin
        bus.HBusReq = 1'b1;
        state_d     = bus.C_config ? ST_START : ST_ABORT;
      end
      ST_START: begin
        bus.HBusReq      = 1'b1;
        bus.con_sel      = chanSel;
        bus.con_en       = 1'b1;
        bus.channel_en_1 = (chanSel == CON_SEL_CH1);
        bus.channel_en_2 = (chanSel == CON_SEL_CH2);
        state_d          = ST_XFER;
      end
      ST_XFER: begin
        bus.HBusReq      = 1'b1;
        bus.con_sel      = chanSel;
        bus.channel_en_1 = (chanSel == CON_SEL_CH1);
        bus.channel_en_2 = (chanSel == CON_SEL_CH2);
        if (bus.irq) state_d = ST_DONE;
      end
      ST_DONE: begin
        bus.DmacAck = (chanSel == CON_SEL_CH2) ? 2'b10 : 2'b01;
        state_d     = ST_IDLE;
      end
      ST_ABORT: begin
        bus.cfg_err = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmac_main_controller.sv
// Self-checking bench for dmac_main_controller with a small datapath stand-in and event scoreboard.
module tb_dmac_main_controller;
  import dmac_pkg::*;

  localparam int EV_DADDR = 1;
  localparam int EV_SIZE  = 2;
  localparam int EV_CTRL  = 3;
  localparam int EV_CH1   = 4;
  localparam int EV_CH2   = 5;
  localparam int EV_ACK1  = 6;
  localparam int EV_ACK2  = 7;
  localparam int EV_ERR   = 8;

  typedef struct {
    logic [1:0]  req;
    bit          setReq;
    int          errIdx;
    logic [31:0] ctrl;
    int          irqDelay;
    int          expChan;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmac_main_controller_if dif();

  dmac_main_controller dut (
    .clk (clk),
    .rst (rst_n),
    .bus (dif)
  );

  // Datapath stand-in: latched request and the Ctrl word's config-valid bit.
  logic [1:0]  dpReq;
  logic [31:0] dpCtrl;
  logic [31:0] ctrlWord;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dpReq  <= 2'b00;
      dpCtrl <= 32'h0;
    end else begin
      if (dif.DmacReq_Reg_en) dpReq <= dif.DmacReq;
      if (dif.Ctrl_Reg_en) dpCtrl <= ctrlWord;
    end
  end

  assign dif.C_config    = dpCtrl[16];
  assign dif.DmacReq_Reg = dpReq;

  int   expQ[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   monEn = 1'b0;
  logic ch1Prev = 1'b0;
  logic ch2Prev = 1'b0;
  int   loadsSeen = 0;
  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic popEvent(input int ev);
    int e;
    e = (expQ.size() == 0) ? 0 : expQ.pop_front();
    checkOutput("scoreboard event", ev, e);
  endtask

  function automatic logic [18:0] outVec();
    return {dif.HBusReq, dif.config_write, dif.config_HTrans, dif.addr_inc_sel, dif.con_sel,
            dif.con_en, dif.DmacReq_Reg_en, dif.SAddr_Reg_en, dif.DAddr_Reg_en,
            dif.Trans_sz_Reg_en, dif.Ctrl_Reg_en, dif.channel_en_1, dif.channel_en_2,
            dif.DmacAck, dif.cfg_err};
  endfunction

  localparam logic [18:0] RESET_VEC = {1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 5'b0, 2'b00, 2'b00, 1'b0};

  // Monitor samples mid-cycle so combinational loads reflect the inputs of that cycle.
  always @(negedge clk) begin
    #1;
    if (monEn) begin
      if (dif.SAddr_Reg_en) loadsSeen = 0;
      if (dif.config_HTrans == HTRANS_NONSEQ) checkOutput("addr_inc_sel", dif.addr_inc_sel, loadsSeen);
      if (dif.config_write) checkOutput("config_write", dif.config_write, 0);
      if (dif.DAddr_Reg_en) begin popEvent(EV_DADDR); loadsSeen++; end
      if (dif.Trans_sz_Reg_en) begin popEvent(EV_SIZE); loadsSeen++; end
      if (dif.Ctrl_Reg_en) begin popEvent(EV_CTRL); loadsSeen++; end
      if (dif.channel_en_1 && !ch1Prev) popEvent(EV_CH1);
      if (dif.channel_en_2 && !ch2Prev) popEvent(EV_CH2);
      if (dif.DmacAck[0]) popEvent(EV_ACK1);
      if (dif.DmacAck[1]) popEvent(EV_ACK2);
      if (dif.cfg_err) popEvent(EV_ERR);
    end
    ch1Prev = dif.channel_en_1;
    ch2Prev = dif.channel_en_2;
  end

  // Called at posedge+1 with the DUT in IDLE; that cycle is cycle 0.
  task automatic applyStimulus(input logic [1:0] req, input bit setReq, input int errIdx,
                               input logic [31:0] ctrl, input int irqDelay, input int expChan,
                               input int grantDelay, input bit stall);
    int         step;
    int         chenCycle;
    int         irqAt;
    bit         done;
    logic [6:0] stallRef;
    step      = stall ? 5 : 2;
    chenCycle = -1;
    irqAt     = -1;
    done      = 1'b0;
    stallRef  = '0;
    for (int k = 0; k < 3; k++) begin
      if (k == errIdx) begin
        expQ.push_back(EV_ERR);
        break;
      end
      expQ.push_back(EV_DADDR + k);
    end
    if (errIdx >= 3) begin
      if (ctrl[16]) begin
        expQ.push_back(expChan == 2 ? EV_CH2 : EV_CH1);
        expQ.push_back(expChan == 2 ? EV_ACK2 : EV_ACK1);
      end else begin
        expQ.push_back(EV_ERR);
      end
    end

    if (setReq) dif.DmacReq = req;
    ctrlWord    = ctrl;
    dif.HGrant  = (grantDelay == 0);
    dif.HReady  = 1'b1;
    dif.M_HResp = HRESP_OKAY;
    dif.irq     = 1'b0;

    for (int c = 1; c <= 400 && !done; c++) begin
      @(posedge clk);
      #1;
      if (chenCycle < 0 && (dif.channel_en_1 || dif.channel_en_2)) begin
        chenCycle = c;
        irqAt     = c + irqDelay;
        checkOutput("start latency", c, 10 + grantDelay + (stall ? 9 : 0));
        checkOutput("start con_sel", dif.con_sel, expChan == 2 ? CON_SEL_CH2 : CON_SEL_CH1);
        checkOutput("start con_en/HBusReq", {dif.con_en, dif.HBusReq}, 2'b11);
      end
      if (dif.DmacAck != 2'b00) begin
        checkOutput("ack cycle", c, irqAt + 1);
        checkOutput("done bus/chan", {dif.HBusReq, dif.channel_en_1, dif.channel_en_2}, 0);
        dif.DmacReq = dif.DmacReq & ~dif.DmacAck;
        done = 1'b1;
      end
      if (dif.cfg_err) begin
        checkOutput("abort bus/chan/ack", {dif.HBusReq, dif.channel_en_1, dif.channel_en_2, dif.DmacAck}, 0);
        dif.DmacReq = 2'b00;
        done = 1'b1;
      end
      if (stall) begin
        for (int k = 0; k < 3; k++) begin
          int d;
          d = 4 + grantDelay + 5 * k;
          if (c == d) stallRef = {dif.HBusReq, dif.config_HTrans, dif.addr_inc_sel, dif.con_sel};
          else if (c > d && c <= d + 3)
            checkOutput("stall hold", {dif.HBusReq, dif.config_HTrans, dif.addr_inc_sel, dif.con_sel}, stallRef);
        end
      end
      dif.HGrant  = (c >= 1 + grantDelay);
      dif.HReady  = 1'b1;
      dif.M_HResp = HRESP_OKAY;
      for (int k = 0; k < 3; k++) begin
        int d;
        d = 4 + grantDelay + step * k;
        if (stall && c >= d && c <= d + 2) dif.HReady = 1'b0;
        if (k == errIdx && c == d + (stall ? 3 : 0)) dif.M_HResp = HRESP_ERROR;
      end
      dif.irq = (c == irqAt);
    end

    checkOutput("sequence completed", done, 1);
    dif.irq     = 1'b0;
    dif.M_HResp = HRESP_OKAY;
    if (dif.DmacReq != 2'b00) begin
      @(posedge clk);
      #1;
    end else begin
      repeat (2) begin
        @(posedge clk);
        #1;
      end
    end
    checkOutput("scoreboard drained", expQ.size(), 0);
    expQ.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{2'b01, 1'b1, 3, 32'h0001_0001, 20, 1};
    vecs[1] = '{2'b11, 1'b1, 3, 32'h0001_0001, 5,  2};
    vecs[2] = '{2'b00, 1'b0, 3, 32'h0001_0001, 3,  1};
    vecs[3] = '{2'b01, 1'b1, 3, 32'h0000_0004, 1,  0};
    vecs[4] = '{2'b10, 1'b1, 1, 32'h0001_0001, 1,  0};
    vecs[5] = '{2'b10, 1'b1, 3, 32'h0001_0001, 1,  2};
    vecs[6] = '{2'b01, 1'b1, 0, 32'h0001_0001, 1,  0};
    vecs[7] = '{2'b01, 1'b1, 2, 32'h0001_0001, 1,  0};

    dif.DmacReq = 2'b00;
    dif.HGrant  = 1'b0;
    dif.HReady  = 1'b1;
    dif.M_HResp = HRESP_OKAY;
    dif.irq     = 1'b0;
    ctrlWord    = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset outputs", outVec(), RESET_VEC);
    rst_n = 1'b1;
    monEn = 1'b1;
    dif.irq = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idle ignores irq", outVec(), RESET_VEC);
    dif.irq = 1'b0;

    for (int i = 0; i < 8; i++) begin
      $display("[TB] vector row %0d", i);
      applyStimulus(vecs[i].req, vecs[i].setReq, vecs[i].errIdx, vecs[i].ctrl,
                    vecs[i].irqDelay, vecs[i].expChan, 0, 1'b0);
    end

    $display("[TB] grant delay with config wait states");
    applyStimulus(2'b01, 1'b1, 3, 32'h0001_0001, 4, 1, 5, 1'b1);

    $display("[TB] reset during transfer");
    expQ.push_back(EV_DADDR);
    expQ.push_back(EV_SIZE);
    expQ.push_back(EV_CTRL);
    expQ.push_back(EV_CH1);
    ctrlWord = 32'h0001_0001;
    dif.HGrant = 1'b1;
    dif.DmacReq = 2'b01;
    repeat (14) @(posedge clk);
    #1;
    checkOutput("xfer channel_en_1", {dif.channel_en_1, dif.HBusReq}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset outputs", outVec(), RESET_VEC);
    checkOutput("pre-reset events", expQ.size(), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(2'b00, 1'b0, 3, 32'h0001_0001, 6, 1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
